alu_seq: RTL and testbench

Parametrised multi-cycle ALU for the 8051 core datapath. Single-cycle arithmetic and logic ops complete in one clock. MUL and DIV run as iterative shift-add and restoring-divide engines over `DATA_W` cycles. The block computes the full PSW flag set (CY, AC, OV, P). It sits between the decoder/controller and the ACC/B/PSW registers, using a start/done handshake so the controller can stall on long ops.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_muldiv_iter.sv | 87 ++++++++
 rtl/alu_seq.sv | 175 +++++++++++++++++
 tb/tb_alu_seq.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the 8051 ALU slice.
//   - ALU opcode encodings (4 bits; 14 and 15 are reserved)
//   - PSW bit positions
//   - handshake FSM state encoding
package alu_pkg;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_ADDC = 4'd1;
   localparam logic [3:0] OP_INC  = 4'd2;
   localparam logic [3:0] OP_DEC  = 4'd3;
   localparam logic [3:0] OP_SUBB = 4'd4;
   localparam logic [3:0] OP_MUL  = 4'd5;
   localparam logic [3:0] OP_DIV  = 4'd6;
   localparam logic [3:0] OP_ANL  = 4'd7;
   localparam logic [3:0] OP_ORL  = 4'd8;
   localparam logic [3:0] OP_XRL  = 4'd9;
   localparam logic [3:0] OP_SETB = 4'd10;
   localparam logic [3:0] OP_CLR  = 4'd11;
   localparam logic [3:0] OP_CPL  = 4'd12;
   localparam logic [3:0] OP_MOV  = 4'd13;

   localparam int PSW_CY = 7;
   localparam int PSW_AC = 6;
   localparam int PSW_OV = 2;
   localparam int PSW_P  = 0;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: iterative unsigned multiply / restoring divide engine.
// One bit per clock over DATA_W clocks, sharing one 2*DATA_W shift register
// ({hi, lo}) between both operations.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : capture a/b/is_div and start a new operation
//   is_div      : 1 = divide a by b, 0 = multiply a by b
//   a, b        : operands
//   step_done   : high during the clock whose edge performs the last step
//   hi, lo      : shift-register contents after the step performed at the
//                 next edge; on step_done they are the final product
//                 (hi:lo) or remainder (hi) / quotient (lo)
module alu_muldiv_iter #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              is_div,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              step_done,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo
);

   localparam int CNT_W = $clog2(DATA_W) + 1;

   logic              run_q;
   logic              div_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] hi_q;
   logic [DATA_W-1:0] lo_q;
   logic [DATA_W-1:0] b_q;
   logic [DATA_W:0]   mul_sum;
   logic [DATA_W:0]   div_trial;
   logic [DATA_W:0]   div_diff;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q <= 1'b0;
         cnt_q <= '0;
      end else if (load) begin
         run_q <= 1'b1;
         cnt_q <= '0;
      end else if (run_q) begin
         if (step_done) begin
            run_q <= 1'b0;
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   // Datapath registers carry no reset; they are only observed while running.
   always_ff @(posedge clk) begin
      if (load) begin
         hi_q  <= '0;
         lo_q  <= a;
         b_q   <= b;
         div_q <= is_div;
      end else if (run_q) begin
         hi_q <= hi;
         lo_q <= lo;
      end
   end

   always_comb begin
      // MUL: add multiplicand into the high half when the current LSB is set,
      // then shift the whole register right one place.
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(DATA_W+1){1'b0}});
      // DIV: shift the next dividend bit into the partial remainder and try
      // a subtract; the remainder is always < b, so no borrow means fit.
      div_trial = {hi_q, lo_q[DATA_W-1]};
      div_diff  = div_trial - {1'b0, b_q};
      if (div_q) begin
         hi = div_diff[DATA_W] ? div_trial[DATA_W-1:0] : div_diff[DATA_W-1:0];
         lo = {lo_q[DATA_W-2:0], ~div_diff[DATA_W]};
      end else begin
         hi = mul_sum[DATA_W:1];
         lo = {mul_sum[0], lo_q[DATA_W-1:1]};
      end
   end

   assign step_done = run_q && (cnt_q == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU for the 8051 datapath with start/done handshake.
// Single-cycle ops finish the clock after start; MUL and DIV (b != 0) run in
// alu_muldiv_iter for DATA_W clocks while busy is high.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : request, sampled only while idle
//   alu_op          : opcode (alu_pkg)
//   a_data, b_data  : operands A (ACC) and B
//   psw_in          : current PSW; CY is carry/borrow in
//   busy            : iterative op in progress
//   done            : one-cycle pulse, results valid from this cycle
//   ans, ans_hi     : result low / high (MUL high, DIV remainder, else 0)
//   psw_out         : updated PSW, held until the next done
module alu_seq
   import alu_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [3:0]        alu_op,
   input  logic [DATA_W-1:0] a_data,
   input  logic [DATA_W-1:0] b_data,
   input  logic [7:0]        psw_in,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] ans,
   output logic [DATA_W-1:0] ans_hi,
   output logic [7:0]        psw_out
);

   state_t            state_q;
   state_t            state_d;
   logic              load;
   logic              accept_sc;
   logic              is_iter;
   logic              step_done;
   logic [DATA_W-1:0] iter_hi;
   logic [DATA_W-1:0] iter_lo;
   logic [7:0]        psw_l;
   logic              div_l;
   logic [7:0]        iter_psw;

   logic              cin;
   logic              cin_add;
   logic [DATA_W:0]   add_full;
   logic [4:0]        add_nib;
   logic [DATA_W:0]   sub_full;
   logic [4:0]        sub_nib;
   logic [DATA_W-1:0] sc_ans;
   logic [DATA_W-1:0] sc_hi;
   logic [7:0]        sc_psw;

   alu_muldiv_iter #(.DATA_W(DATA_W)) u_iter (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .is_div    (alu_op == OP_DIV),
      .a         (a_data),
      .b         (b_data),
      .step_done (step_done),
      .hi        (iter_hi),
      .lo        (iter_lo)
   );

   // Divide by zero is resolved in one clock, so only nonzero-B DIV iterates.
   assign is_iter = (alu_op == OP_MUL) || ((alu_op == OP_DIV) && (b_data != '0));

   always_comb begin
      state_d   = state_q;
      load      = 1'b0;
      accept_sc = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (is_iter) begin
                  state_d = RUN;
                  load    = 1'b1;
               end else begin
                  accept_sc = 1'b1;
               end
            end
         end
         RUN: begin
            if (step_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cin      = psw_in[PSW_CY];
      cin_add  = (alu_op == OP_ADDC) && cin;
      add_full = {1'b0, a_data} + {1'b0, b_data} + {{DATA_W{1'b0}}, cin_add};
      add_nib  = {1'b0, a_data[3:0]} + {1'b0, b_data[3:0]} + {4'b0, cin_add};
      sub_full = {1'b0, a_data} - {1'b0, b_data} - {{DATA_W{1'b0}}, cin};
      sub_nib  = {1'b0, a_data[3:0]} - {1'b0, b_data[3:0]} - {4'b0, cin};
      sc_ans   = a_data;
      sc_hi    = '0;
      sc_psw   = psw_in;
      case (alu_op)
         OP_ADD, OP_ADDC: begin
            sc_ans         = add_full[DATA_W-1:0];
            sc_psw[PSW_CY] = add_full[DATA_W];
            sc_psw[PSW_AC] = add_nib[4];
            sc_psw[PSW_OV] = (a_data[DATA_W-1] == b_data[DATA_W-1]) &&
                             (add_full[DATA_W-1] != a_data[DATA_W-1]);
         end
         OP_SUBB: begin
            sc_ans         = sub_full[DATA_W-1:0];
            sc_psw[PSW_CY] = sub_full[DATA_W];
            sc_psw[PSW_AC] = sub_nib[4];
            sc_psw[PSW_OV] = (a_data[DATA_W-1] != b_data[DATA_W-1]) &&
                             (sub_full[DATA_W-1] != a_data[DATA_W-1]);
         end
         OP_INC:  sc_ans = a_data + DATA_W'(1);
         OP_DEC:  sc_ans = a_data - DATA_W'(1);
         OP_ANL:  sc_ans = a_data & b_data;
         OP_ORL:  sc_ans = a_data | b_data;
         OP_XRL:  sc_ans = a_data ^ b_data;
         OP_SETB: sc_ans = DATA_W'(1);
         OP_CLR:  sc_ans = '0;
         OP_CPL:  sc_ans = ~a_data;
         OP_MOV:  sc_ans = b_data;
         OP_DIV: begin
            sc_ans         = '1;
            sc_hi          = a_data;
            sc_psw[PSW_CY] = 1'b0;
            sc_psw[PSW_OV] = 1'b1;
         end
         default: sc_ans = a_data;
      endcase
      sc_psw[PSW_P] = ^sc_ans;
   end

   always_comb begin
      iter_psw         = psw_l;
      iter_psw[PSW_CY] = 1'b0;
      iter_psw[PSW_OV] = div_l ? 1'b0 : (iter_hi != '0);
      iter_psw[PSW_P]  = ^iter_lo;
   end

   // Flags and op kind for iterative ops are captured at acceptance.
   always_ff @(posedge clk) begin
      if (load) begin
         psw_l <= psw_in;
         div_l <= (alu_op == OP_DIV);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         done    <= 1'b0;
         ans     <= '0;
         ans_hi  <= '0;
         psw_out <= '0;
      end else begin
         state_q <= state_d;
         done    <= accept_sc || ((state_q == RUN) && step_done);
         if (accept_sc) begin
            ans     <= sc_ans;
            ans_hi  <= sc_hi;
            psw_out <= sc_psw;
         end else if ((state_q == RUN) && step_done) begin
            ans     <= iter_lo;
            ans_hi  <= iter_hi;
            psw_out <= iter_psw;
         end
      end
   end

   assign busy = (state_q == RUN);

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed bench for alu_seq at DATA_W = 8. Expected results are
// pushed to a scoreboard queue when each op is issued and popped on done.
module tb_alu_seq;
   import alu_pkg::*;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [3:0]   alu_op = '0;
   logic [W-1:0] a_data = '0;
   logic [W-1:0] b_data = '0;
   logic [7:0]   psw_in = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] ans;
   logic [W-1:0] ans_hi;
   logic [7:0]   psw_out;

   typedef struct {
      logic [7:0] ans;
      logic [7:0] hi;
      logic [7:0] psw;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail = 0;

   alu_seq #(.DATA_W(W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .alu_op  (alu_op),
      .a_data  (a_data),
      .b_data  (b_data),
      .psw_in  (psw_in),
      .busy    (busy),
      .done    (done),
      .ans     (ans),
      .ans_hi  (ans_hi),
      .psw_out (psw_out)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one start for a clock; afterwards scramble the inputs so that any
   // use of un-latched operands shows up as a wrong result.
   task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] p, input logic push,
                        input logic [7:0] ea, input logic [7:0] eh, input logic [7:0] ep);
      exp_t e;
      alu_op = op;
      a_data = a;
      b_data = b;
      psw_in = p;
      start  = 1'b1;
      if (push) begin
         e.ans = ea;
         e.hi  = eh;
         e.psw = ep;
         sb.push_back(e);
      end
      tick();
      start  = 1'b0;
      a_data = ~a;
      b_data = ~b;
      psw_in = ~p;
      alu_op = op ^ 4'h3;
   endtask

   // Called in cycle 'first' after acceptance; waits for done and checks
   // latency, busy behaviour and the scoreboard entry.
   task automatic wait_done(input string tag, input int first, input int lat, input logic chk_busy);
      int   cyc;
      logic busy_ok;
      exp_t e;
      cyc = first;
      busy_ok = 1'b1;
      while (!done && cyc < 40) begin
         if (!busy) busy_ok = 1'b0;
         tick();
         cyc++;
      end
      check({tag, " latency"}, 32'(cyc), 32'(lat));
      if (chk_busy) begin
         check({tag, " busy while running"}, 32'(busy_ok), 32'd1);
         check({tag, " busy at done"}, 32'(busy), 32'd0);
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         if (done) begin
            check({tag, " ans"}, 32'(ans), 32'(e.ans));
            check({tag, " ans_hi"}, 32'(ans_hi), 32'(e.hi));
            check({tag, " psw"}, 32'(psw_out), 32'(e.psw));
         end
      end else begin
         check({tag, " scoreboard entry present"}, 32'(sb.size()), 32'd1);
      end
   endtask

   initial begin
      int seen;

      repeat (2) @(posedge clk);
      #1;
      check("reset ans", 32'(ans), 32'd0);
      check("reset ans_hi", 32'(ans_hi), 32'd0);
      check("reset psw", 32'(psw_out), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      rst_n = 1'b1;
      tick();

      // Single-cycle ops, issued back-to-back from each done cycle.
      issue(OP_ADD, 8'h7F, 8'h01, 8'h18, 1'b1, 8'h80, 8'h00, 8'h5D);
      wait_done("add_ov", 1, 1, 1'b0);
      issue(OP_ADDC, 8'h0F, 8'hF0, 8'h80, 1'b1, 8'h00, 8'h00, 8'hC0);
      wait_done("addc", 1, 1, 1'b0);
      issue(OP_SUBB, 8'h00, 8'h01, 8'h80, 1'b1, 8'hFE, 8'h00, 8'hC1);
      wait_done("subb_borrow", 1, 1, 1'b0);
      issue(OP_INC, 8'hFF, 8'h33, 8'hC4, 1'b1, 8'h00, 8'h00, 8'hC4);
      wait_done("inc_wrap", 1, 1, 1'b0);
      issue(OP_XRL, 8'hA5, 8'h0F, 8'h01, 1'b1, 8'hAA, 8'h00, 8'h00);
      wait_done("xrl", 1, 1, 1'b0);
      issue(OP_CPL, 8'h0E, 8'h00, 8'h00, 1'b1, 8'hF1, 8'h00, 8'h01);
      wait_done("cpl", 1, 1, 1'b0);
      issue(4'd14, 8'h07, 8'h55, 8'h84, 1'b1, 8'h07, 8'h00, 8'h85);
      wait_done("reserved", 1, 1, 1'b0);
      tick();
      check("done single pulse", 32'(done), 32'd0);
      check("hold ans", 32'(ans), 32'h07);
      check("hold psw", 32'(psw_out), 32'h85);

      // Iterative ops.
      issue(OP_MUL, 8'h50, 8'hA0, 8'h00, 1'b1, 8'h00, 8'h32, 8'h04);
      wait_done("mul_hi", 1, 9, 1'b1);
      tick();
      issue(OP_DIV, 8'hFB, 8'h12, 8'h80, 1'b1, 8'h0D, 8'h11, 8'h01);
      wait_done("div", 1, 9, 1'b1);
      issue(OP_DIV, 8'h3C, 8'h00, 8'h00, 1'b1, 8'hFF, 8'h3C, 8'h04);
      wait_done("div_zero", 1, 1, 1'b0);

      // Start during MUL is dropped; ADD in the done cycle is accepted.
      tick();
      issue(OP_MUL, 8'hFF, 8'hFF, 8'h00, 1'b1, 8'h01, 8'hFE, 8'h05);
      tick();
      tick();
      alu_op = OP_ADD;
      a_data = 8'h01;
      b_data = 8'h01;
      psw_in = 8'h00;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      wait_done("mul_ignore", 4, 9, 1'b1);
      issue(OP_ADD, 8'h12, 8'h34, 8'h00, 1'b1, 8'h46, 8'h00, 8'h01);
      wait_done("add_after_mul", 1, 1, 1'b0);
      tick();
      check("no extra done", 32'(done), 32'd0);

      // Reset in the middle of a MUL.
      issue(OP_MUL, 8'h50, 8'hA0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
      tick();
      tick();
      tick();
      check("busy before abort", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort busy", 32'(busy), 32'd0);
      check("abort ans", 32'(ans), 32'd0);
      check("abort ans_hi", 32'(ans_hi), 32'd0);
      check("abort psw", 32'(psw_out), 32'd0);
      check("abort done", 32'(done), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done) seen++;
      end
      check("no done after abort", 32'(seen), 32'd0);
      issue(OP_MUL, 8'h0F, 8'h0F, 8'h00, 1'b1, 8'hE1, 8'h00, 8'h00);
      wait_done("mul_after_reset", 1, 9, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
